// File: rtl/perceptron_epoch_sequencer_if.sv
// Sample/result handshake between the epoch sequencer (master) and the
// single-neuron trainer (slave).
interface perceptron_epoch_sequencer_if #(
  parameter int DATA_W = 32
) ();
  logic                     valid;
  logic                     ready;
  logic signed [DATA_W-1:0] x1;
  logic signed [DATA_W-1:0] x2;
  logic signed [DATA_W-1:0] target;
  logic                     result_valid;
  logic                     error;

  modport master (
    output valid, x1, x2, target,
    input  ready, result_valid, error
  );

  modport slave (
    input  valid, x1, x2, target,
    output ready, result_valid, error
  );
endinterface

// File: rtl/perceptron_epoch_sequencer.sv
// Walks a programmable sample table through the neuron trainer once per epoch,
// tallying per-sample errors and stopping on a clean epoch or the epoch limit.
module perceptron_epoch_sequencer #(
  parameter  int NUM_SAMPLES = 4,
  parameter  int MAX_EPOCHS  = 16,
  parameter  int DATA_W      = 32,
  localparam int ADDR_W      = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
  localparam int EPOCH_W     = $clog2(MAX_EPOCHS + 1),
  localparam int ERR_W       = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic                     cfg_we_i,
  input  logic [ADDR_W-1:0]        cfg_addr_i,
  input  logic signed [DATA_W-1:0] cfg_x1_i,
  input  logic signed [DATA_W-1:0] cfg_x2_i,
  input  logic signed [DATA_W-1:0] cfg_target_i,
  perceptron_epoch_sequencer_if.master trn,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     converged_o,
  output logic [EPOCH_W-1:0]       epoch_count_o,
  output logic [ERR_W-1:0]         last_err_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RES, EPOCH_END, DONE} state_e;

  typedef struct packed {
    logic signed [DATA_W-1:0] x1;
    logic signed [DATA_W-1:0] x2;
    logic signed [DATA_W-1:0] target;
  } sample_t;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d, idx_nxt;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [EPOCH_W-1:0]  epoch_q, epoch_d;
  logic [ERR_W-1:0]    last_err_q, last_err_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                conv_q, conv_d;
  logic                cfg_open;
  sample_t             smp_q, smp_d;
  sample_t             tab_q [NUM_SAMPLES];
  sample_t             tab_d [NUM_SAMPLES];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    epoch_d    = epoch_q;
    last_err_d = last_err_q;
    conv_d     = conv_q;
    smp_d      = smp_q;
    tab_d      = tab_q;
    idx_nxt    = idx_q + ADDR_W'(1);
    cfg_open   = (state_q == IDLE) || (state_q == DONE);

    // Out-of-range addresses simply match no entry.
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      if (cfg_we_i && cfg_open && (cfg_addr_i == ADDR_W'(i))) begin
        tab_d[i] = {cfg_x1_i, cfg_x2_i, cfg_target_i};
      end
    end

    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      conv_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_d    = ISSUE;
            conv_d     = 1'b0;
            epoch_d    = '0;
            last_err_d = '0;
            idx_d      = '0;
            err_d      = '0;
            smp_d      = tab_q[0];
          end
        end
        ISSUE: begin
          if (trn.ready) state_d = WAIT_RES;
        end
        WAIT_RES: begin
          if (trn.result_valid) begin
            if (trn.error && (err_q != ERR_W'(NUM_SAMPLES))) err_d = err_q + ERR_W'(1);
            if (idx_q == ADDR_W'(NUM_SAMPLES - 1)) begin
              state_d = EPOCH_END;
            end else begin
              idx_d   = idx_nxt;
              smp_d   = tab_q[idx_nxt];
              state_d = ISSUE;
            end
          end
        end
        EPOCH_END: begin
          epoch_d    = epoch_q + EPOCH_W'(1);
          last_err_d = err_q;
          if (err_q == '0) begin
            state_d = DONE;
            conv_d  = 1'b1;
          end else if (epoch_d == EPOCH_W'(MAX_EPOCHS)) begin
            state_d = DONE;
          end else begin
            idx_d   = '0;
            err_d   = '0;
            smp_d   = tab_q[0];
            state_d = ISSUE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Status flags are registered copies of the next state so they line up with it.
    valid_d = (state_d == ISSUE);
    busy_d  = (state_d == ISSUE) || (state_d == WAIT_RES) || (state_d == EPOCH_END);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      err_q      <= '0;
      epoch_q    <= '0;
      last_err_q <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conv_q     <= 1'b0;
      smp_q      <= '0;
      for (int i = 0; i < NUM_SAMPLES; i++) tab_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      epoch_q    <= epoch_d;
      last_err_q <= last_err_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conv_q     <= conv_d;
      smp_q      <= smp_d;
      tab_q      <= tab_d;
    end
  end

  assign trn.valid     = valid_q;
  assign trn.x1        = smp_q.x1;
  assign trn.x2        = smp_q.x2;
  assign trn.target    = smp_q.target;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign converged_o   = conv_q;
  assign epoch_count_o = epoch_q;
  assign last_err_o    = last_err_q;

endmodule

// File: doc/perceptron_epoch_sequencer.md
Name: perceptron_epoch_sequencer

Overview:
- Controller that feeds a programmable training-sample table to the single-neuron trainer, one sample at a time, over a valid/ready handshake.
- Collects a per-sample error flag from the trainer and counts epochs.
- Stops early on the first epoch with zero errors (converged) or after MAX_EPOCHS epochs.
- Sits between the top-level control/host and the neuron trainer datapath.

Parameters:
- NUM_SAMPLES, 4, number of entries in the sample table (>=1)
- MAX_EPOCHS, 16, epoch limit before giving up (>=1)
- DATA_W, 32, sample word width (1 sign + 15 integer + 16 fraction fixed point)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- start_i  in  1  begin a training run (pulse)
- abort_i  in  1  cancel the run in progress
- cfg_we_i  in  1  sample table write enable
- cfg_addr_i  in  $clog2(NUM_SAMPLES) (min 1)  table entry index
- cfg_x1_i, cfg_x2_i, cfg_target_i  in  DATA_W each  entry contents
- valid_o  out  1  sample presented to the trainer
- ready_i  in  1  trainer accepts the sample
- x1_o, x2_o, target_o  out  DATA_W each  current sample
- result_valid_i  in  1  trainer finished the accepted sample
- error_i  in  1  neuron output differed from the target (qualified by result_valid_i)
- busy_o  out  1  run in progress
- done_o  out  1  run finished (sticky until next start/abort)
- converged_o  out  1  run ended on a zero-error epoch
- epoch_count_o  out  $clog2(MAX_EPOCHS+1)  epochs completed
- last_err_o  out  $clog2(NUM_SAMPLES+1)  error count of the last completed epoch

Behaviour:
- Reset: state IDLE. All outputs 0. Table entries cleared to 0. Sample index, epoch counter and error counter cleared to 0.
- States: IDLE, ISSUE, WAIT_RES, EPOCH_END, DONE.
- Config write: accepted only in IDLE or DONE. Ignored in all other states. Ignored when cfg_addr_i >= NUM_SAMPLES. Written data is visible from the next cycle.
- start_i in IDLE or DONE:
  - clears done_o, converged_o, epoch_count_o, last_err_o, sample index and epoch error count
  - goes to ISSUE; valid_o is high in the cycle after start_i is sampled
  - start_i is ignored in every other state.
- ISSUE:
  - valid_o=1 and x1_o/x2_o/target_o = table[idx], held stable until ready_i.
  - On valid_o&&ready_i, go to WAIT_RES; valid_o drops the next cycle.
  - Only one sample is outstanding at a time.
- WAIT_RES:
  - On result_valid_i, the epoch error count increments if error_i is set (saturating at NUM_SAMPLES).
  - If idx==NUM_SAMPLES-1, go to EPOCH_END; otherwise idx++ and go to ISSUE.
  - result_valid_i in any other state is ignored.
- EPOCH_END (exactly one cycle):
  - epoch_count_o++ and last_err_o <= epoch error count.
  - If the epoch error count is 0: go to DONE with converged_o=1.
  - Else if the new epoch count == MAX_EPOCHS: go to DONE with converged_o=0.
  - Else: idx=0, epoch error count=0, go to ISSUE.
- DONE: done_o=1, busy_o=0, data outputs hold the last sample; stays here until start_i or abort_i.
- busy_o=1 in ISSUE, WAIT_RES and EPOCH_END.
- abort_i in any state except IDLE:
  - next state is IDLE; valid_o drops the next cycle
  - done_o and converged_o are cleared
  - epoch_count_o and last_err_o hold their values
  - abort_i has priority over start_i, ready_i and result_valid_i in the same cycle.
- Asynchronous reset mid-run: immediate return to reset values; no partial handshake is kept.
- Latency for a ready trainer with 1-cycle result: 3 cycles per sample plus 1 per epoch.

Test Plan:
- OR table {(0,0,0),(1,0,1),(0,1,1),(1,1,1)}, error_i=1 on sample 0 in epochs 1–2 and 0 afterwards, then start -> converged_o=1, done_o=1, epoch_count_o=3, last_err_o=0, 12 handshakes.
- MAX_EPOCHS=4, error_i always 1 -> done_o=1, converged_o=0, epoch_count_o=4, last_err_o=4, exactly 16 valid&&ready transfers.
- ready_i held low 3 cycles in ISSUE -> valid_o stays high; x1_o/x2_o/target_o are stable across all 3 cycles; exactly one transfer occurs.
- cfg write to addr 1 while busy -> table unchanged (epoch 2 still presents the old entry 1); the same write in DONE -> takes effect on the next run.
- abort_i in WAIT_RES of epoch 2 (together with result_valid_i) -> IDLE next cycle, busy_o=0, done_o=0, epoch_count_o=1; a following start restarts at sample 0 with epoch_count_o=0.
- reset_i asserted mid-ISSUE -> valid_o=0 and all status outputs 0 immediately; the table reads 0 afterwards.
